// File: rtl/ttl_dec.sv
// IPv4 TTL-decrement stage with a one-beat output register and checksum-offload sideband.
// Optional macro TTL_DEC_DROP_CNT_EN builds the saturating drop counter; otherwise drop_count is tied to 0.
module ttl_dec #(
    parameter int DATA_WIDTH      = 600,
    parameter int EMPTY_WIDTH     = $clog2(DATA_WIDTH / 8),
    parameter int CHANNEL_WIDTH   = 6,
    parameter int ERROR_WIDTH     = 4,
    parameter int AVST_ADDR_WIDTH = 9,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      stream_in_data,
    input  logic [EMPTY_WIDTH-1:0]     stream_in_empty,
    input  logic                       stream_in_valid,
    output logic                       stream_in_ready,
    input  logic                       stream_in_startofpacket,
    input  logic                       stream_in_endofpacket,
    input  logic [CHANNEL_WIDTH-1:0]   stream_in_channel,
    input  logic [ERROR_WIDTH-1:0]     stream_in_error,
    output logic [DATA_WIDTH-1:0]      stream_out_data,
    output logic [EMPTY_WIDTH-1:0]     stream_out_empty,
    output logic                       stream_out_valid,
    input  logic                       stream_out_ready,
    output logic                       stream_out_startofpacket,
    output logic                       stream_out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0]   stream_out_channel,
    output logic [ERROR_WIDTH-1:0]     stream_out_error,
    output logic                       csum_enable,
    output logic [AVST_ADDR_WIDTH-1:0] csum_start,
    output logic [AVST_ADDR_WIDTH-1:0] csum_offset,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    localparam int ETYPE_MSB = DATA_WIDTH - 97;
    localparam int TTL_MSB   = DATA_WIDTH - 177;
    localparam logic [AVST_ADDR_WIDTH-1:0] CSUM_START  = AVST_ADDR_WIDTH'(DATA_WIDTH - 272);
    localparam logic [AVST_ADDR_WIDTH-1:0] CSUM_OFFSET = AVST_ADDR_WIDTH'(DATA_WIDTH - 208);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                     r_state;
    logic [DATA_WIDTH-1:0]      r_out_data;
    logic [EMPTY_WIDTH-1:0]     r_out_empty;
    logic                       r_out_valid;
    logic                       r_out_sop;
    logic                       r_out_eop;
    logic [CHANNEL_WIDTH-1:0]   r_out_channel;
    logic [ERROR_WIDTH-1:0]     r_out_error;
    logic                       r_csum_enable;
    logic [AVST_ADDR_WIDTH-1:0] r_csum_start;
    logic [AVST_ADDR_WIDTH-1:0] r_csum_offset;

    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_is_ipv4;
    logic [7:0]            w_ttl;
    logic                  w_expired;
    logic                  w_new_pkt;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;

    // While discarding a packet the output register is untouched, so input never needs to stall.
    assign w_in_ready = (r_state == DROP) || !r_out_valid || stream_out_ready;
    assign w_in_fire  = stream_in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && stream_out_ready;
    assign w_is_ipv4  = (stream_in_data[ETYPE_MSB -: 16] == 16'h0800);
    assign w_ttl      = stream_in_data[TTL_MSB -: 8];
    assign w_expired  = w_is_ipv4 && (w_ttl < 8'd2);
    assign w_new_pkt  = w_in_fire && stream_in_startofpacket && (r_state != DROP);
    assign w_load     = w_new_pkt ? !w_expired : (w_in_fire && (r_state == FWD));

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_load_data = stream_in_data;
        if (w_new_pkt && w_is_ipv4) begin
            w_load_data[TTL_MSB -: 8] = w_ttl - 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_out_data    <= '0;
            r_out_empty   <= '0;
            r_out_valid   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_channel <= '0;
            r_out_error   <= '0;
            r_csum_enable <= 1'b0;
            r_csum_start  <= '0;
            r_csum_offset <= '0;
        end else begin
            if (w_out_fire) begin
                r_out_valid   <= 1'b0;
                r_csum_enable <= 1'b0;
            end

            if (w_load) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_load_data;
                r_out_empty   <= stream_in_empty;
                r_out_sop     <= stream_in_startofpacket;
                r_out_eop     <= stream_in_endofpacket;
                r_out_channel <= stream_in_channel;
                r_out_error   <= stream_in_error;
                r_csum_enable <= w_new_pkt && w_is_ipv4;
                if (w_new_pkt && w_is_ipv4) begin
                    r_csum_start  <= CSUM_START;
                    r_csum_offset <= CSUM_OFFSET;
                end
            end

            if (w_new_pkt) begin
                if (stream_in_endofpacket) begin
                    r_state <= IDLE;
                end else begin
                    r_state <= w_expired ? DROP : FWD;
                end
            end else if (w_in_fire && stream_in_endofpacket && (r_state != IDLE)) begin
                r_state <= IDLE;
            end
        end
    end

`ifdef TTL_DEC_DROP_CNT_EN
    logic                 w_drop_done;
    logic [CNT_WIDTH-1:0] r_drop_count;

    assign w_drop_done = w_in_fire && stream_in_endofpacket &&
                         ((r_state == DROP) || (w_new_pkt && w_expired));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop_done && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

    assign stream_in_ready          = w_in_ready;
    assign stream_out_data          = r_out_data;
    assign stream_out_empty         = r_out_empty;
    assign stream_out_valid         = r_out_valid;
    assign stream_out_startofpacket = r_out_sop;
    assign stream_out_endofpacket   = r_out_eop;
    assign stream_out_channel       = r_out_channel;
    assign stream_out_error         = r_out_error;
    assign csum_enable              = r_csum_enable;
    assign csum_start               = r_csum_start;
    assign csum_offset              = r_csum_offset;

endmodule

// File: tb/tb_ttl_dec.sv
// Bench for ttl_dec: directed steps plus random packets, scored against a packet-level reference model.
// Drop counter expectations follow whether TTL_DEC_DROP_CNT_EN is defined.
module tb_ttl_dec;

    localparam int DW  = 600;
    localparam int EW  = $clog2(DW / 8);
    localparam int CW  = 6;
    localparam int ERW = 4;
    localparam int AW  = 9;
    localparam int NW  = 32;
    localparam int ETYPE_MSB = DW - 97;
    localparam int TTL_MSB   = DW - 177;

    typedef struct {
        logic [DW-1:0]  data;
        logic [EW-1:0]  empty;
        logic [CW-1:0]  channel;
        logic [ERW-1:0] error;
        logic           sop;
        logic           eop;
        logic           csum;
    } beat_t;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  stream_in_data;
    logic [EW-1:0]  stream_in_empty;
    logic           stream_in_valid;
    logic           stream_in_ready;
    logic           stream_in_startofpacket;
    logic           stream_in_endofpacket;
    logic [CW-1:0]  stream_in_channel;
    logic [ERW-1:0] stream_in_error;
    logic [DW-1:0]  stream_out_data;
    logic [EW-1:0]  stream_out_empty;
    logic           stream_out_valid;
    logic           stream_out_ready;
    logic           stream_out_startofpacket;
    logic           stream_out_endofpacket;
    logic [CW-1:0]  stream_out_channel;
    logic [ERW-1:0] stream_out_error;
    logic           csum_enable;
    logic [AW-1:0]  csum_start;
    logic [AW-1:0]  csum_offset;
    logic [NW-1:0]  drop_count;

    ttl_dec dut (
        .clk                      (clk),
        .rst                      (rst),
        .stream_in_data           (stream_in_data),
        .stream_in_empty          (stream_in_empty),
        .stream_in_valid          (stream_in_valid),
        .stream_in_ready          (stream_in_ready),
        .stream_in_startofpacket  (stream_in_startofpacket),
        .stream_in_endofpacket    (stream_in_endofpacket),
        .stream_in_channel        (stream_in_channel),
        .stream_in_error          (stream_in_error),
        .stream_out_data          (stream_out_data),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_ready         (stream_out_ready),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_channel       (stream_out_channel),
        .stream_out_error         (stream_out_error),
        .csum_enable              (csum_enable),
        .csum_start               (csum_start),
        .csum_offset              (csum_offset),
        .drop_count               (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit bp_random = 0;

    // Reference model: expected output beats, packet context and drop total.
    beat_t         exp_q[$];
    bit            m_in_pkt;
    bit            m_dropping;
    logic [NW-1:0] m_drops;
    beat_t         mon_e;
    beat_t         mon_in;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] exp_drops();
`ifdef TTL_DEC_DROP_CNT_EN
        return m_drops;
`else
        return '0;
`endif
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_in_pkt   = 0;
        m_dropping = 0;
        m_drops    = '0;
    endfunction

    function automatic void model_accept(input beat_t b);
        beat_t         o;
        logic [15:0]   et;
        logic [7:0]    ttl;
        logic [DW-1:0] d;
        d   = b.data;
        et  = d[ETYPE_MSB -: 16];
        ttl = d[TTL_MSB -: 8];
        o   = b;
        o.csum = 0;
        if (m_dropping) begin
            if (b.eop) begin
                m_dropping = 0;
                if (m_drops != '1) m_drops = m_drops + 1;
            end
        end else if (b.sop) begin
            m_in_pkt = 0;
            if (et == 16'h0800 && ttl <= 1) begin
                if (b.eop) begin
                    if (m_drops != '1) m_drops = m_drops + 1;
                end else begin
                    m_dropping = 1;
                end
            end else begin
                if (et == 16'h0800) begin
                    d[TTL_MSB -: 8] = ttl - 8'd1;
                    o.data = d;
                    o.csum = 1;
                end
                exp_q.push_back(o);
                m_in_pkt = !b.eop;
            end
        end else if (m_in_pkt) begin
            exp_q.push_back(o);
            if (b.eop) m_in_pkt = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (stream_out_valid && stream_out_ready) begin
                chk("out_expected", 600'(exp_q.size() != 0), 600'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data",    stream_out_data,          mon_e.data);
                    chk("out_empty",   600'(stream_out_empty),   600'(mon_e.empty));
                    chk("out_channel", 600'(stream_out_channel), 600'(mon_e.channel));
                    chk("out_error",   600'(stream_out_error),   600'(mon_e.error));
                    chk("out_sop",     600'(stream_out_startofpacket), 600'(mon_e.sop));
                    chk("out_eop",     600'(stream_out_endofpacket),   600'(mon_e.eop));
                    chk("csum_enable", 600'(csum_enable),        600'(mon_e.csum));
                    if (mon_e.csum) begin
                        chk("csum_start",  600'(csum_start),  600'(DW - 272));
                        chk("csum_offset", 600'(csum_offset), 600'(DW - 208));
                    end
                end
            end
            if (m_dropping && stream_in_valid) begin
                chk("drop_ready", 600'(stream_in_ready), 600'(1));
            end
            if (stream_in_valid && stream_in_ready) begin
                mon_in.data    = stream_in_data;
                mon_in.empty   = stream_in_empty;
                mon_in.channel = stream_in_channel;
                mon_in.error   = stream_in_error;
                mon_in.sop     = stream_in_startofpacket;
                mon_in.eop     = stream_in_endofpacket;
                mon_in.csum    = 0;
                model_accept(mon_in);
            end
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW; i += 32) d = {d[DW-33:0], 32'($urandom)};
        return d;
    endfunction

    function automatic beat_t mk(input logic sop, input logic eop, input logic [15:0] et, input logic [7:0] ttl);
        beat_t b;
        b.data = rand_data();
        if (sop) begin
            b.data[ETYPE_MSB -: 16] = et;
            b.data[TTL_MSB -: 8]    = ttl;
        end
        b.empty   = eop ? EW'($urandom_range(0, DW / 8 - 1)) : '0;
        b.channel = CW'($urandom);
        b.error   = ERW'($urandom);
        b.sop     = sop;
        b.eop     = eop;
        b.csum    = 0;
        return b;
    endfunction

    task automatic set_in(input beat_t b);
        stream_in_data          = b.data;
        stream_in_empty         = b.empty;
        stream_in_channel       = b.channel;
        stream_in_error         = b.error;
        stream_in_startofpacket = b.sop;
        stream_in_endofpacket   = b.eop;
        stream_in_valid         = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the beat, valid still high.
    task automatic drive(input beat_t b);
        int n;
        set_in(b);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (stream_in_ready) break;
            @(posedge clk);
            #1;
            if (bp_random) stream_out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("accept_timeout", 600'(n < 200), 600'(1));
        @(posedge clk);
        #1;
        if (bp_random) stream_out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle();
        stream_in_valid         = 1'b0;
        stream_in_startofpacket = 1'b0;
        stream_in_endofpacket   = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 600'(exp_q.size()), 600'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  600'(stream_out_valid), 600'(0));
        chk({tag, "_data"},   stream_out_data, '0);
        chk({tag, "_sop"},    600'({stream_out_startofpacket, stream_out_endofpacket}), 600'(0));
        chk({tag, "_side"},   600'({stream_out_empty, stream_out_channel, stream_out_error}), 600'(0));
        chk({tag, "_csum"},   600'({csum_enable, csum_start, csum_offset}), 600'(0));
        chk({tag, "_drops"},  600'(drop_count), 600'(0));
    endtask

    initial begin
        beat_t b;
        beat_t hold;
        logic [DW-1:0] want;
        logic [15:0] et;
        logic [7:0]  ttl;
        int len;

        rst = 1'b1;
        stream_out_ready = 1'b1;
        stream_in_data = '0;
        stream_in_empty = '0;
        stream_in_channel = '0;
        stream_in_error = '0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_in_ready", 600'(stream_in_ready), 600'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat IPv4, TTL 64: one-cycle latency, TTL 63, checksum sideband set.
        b = mk(1, 1, 16'h0800, 8'd64);
        drive(b);
        idle();
        want = b.data;
        want[TTL_MSB -: 8] = 8'd63;
        chk("t1_valid", 600'(stream_out_valid), 600'(1));
        chk("t1_data", stream_out_data, want);
        chk("t1_ttl", 600'(stream_out_data[TTL_MSB -: 8]), 600'(63));
        chk("t1_csum_en", 600'(csum_enable), 600'(1));
        chk("t1_csum_start", 600'(csum_start), 600'(328));
        chk("t1_csum_offset", 600'(csum_offset), 600'(392));
        drain();

        // 3-beat IPv4 with TTL 1: whole packet dropped.
        drive(mk(1, 0, 16'h0800, 8'd1));
        drive(mk(0, 0, 16'h0000, 8'd0));
        drive(mk(0, 1, 16'h0000, 8'd0));
        idle();
        @(posedge clk);
        #1;
        chk("t2_no_out", 600'(stream_out_valid), 600'(0));
        chk("t2_drops", 600'(drop_count), 600'(exp_drops()));
        drain();

        // 2-beat ARP with TTL byte 0: forwarded unmodified.
        drive(mk(1, 0, 16'h0806, 8'd0));
        drive(mk(0, 1, 16'h0000, 8'd0));
        idle();
        drain();

        // Output stall of 5 cycles in the middle of a 3-beat IPv4 packet.
        drive(mk(1, 0, 16'h0800, 8'd20));
        stream_out_ready = 1'b0;
        hold = mk(0, 0, 16'h0000, 8'd0);
        set_in(hold);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 600'(stream_in_ready), 600'(0));
            chk("stall_valid", 600'(stream_out_valid), 600'(1));
            chk("stall_data", stream_out_data, exp_q[0].data);
        end
        @(posedge clk);
        #1;
        stream_out_ready = 1'b1;
        drive(hold);
        drive(mk(0, 1, 16'h0000, 8'd0));
        idle();
        drain();

        // Back-to-back with continuous valid: TTL 5, TTL 0 (dropped), TTL 9.
        drive(mk(1, 0, 16'h0800, 8'd5));
        drive(mk(0, 1, 16'h0000, 8'd0));
        drive(mk(1, 0, 16'h0800, 8'd0));
        drive(mk(0, 1, 16'h0000, 8'd0));
        drive(mk(1, 0, 16'h0800, 8'd9));
        drive(mk(0, 1, 16'h0000, 8'd0));
        idle();
        drain();
        chk("b2b_drops", 600'(drop_count), 600'(exp_drops()));

        // Reset while discarding, then tail beats without SOP, then a fresh TTL 10 packet.
        drive(mk(1, 0, 16'h0800, 8'd0));
        drive(mk(0, 0, 16'h0000, 8'd0));
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(0, 0, 16'h0000, 8'd0));
        drive(mk(0, 1, 16'h0000, 8'd0));
        drive(mk(1, 1, 16'h0800, 8'd10));
        idle();
        chk("rst_ttl9", 600'(stream_out_data[TTL_MSB -: 8]), 600'(9));
        drain();
        chk("rst_drops", 600'(drop_count), 600'(0));

        // Random traffic with output backpressure and occasional stray beats.
        bp_random = 1;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0) drive(mk(0, $urandom_range(0, 1) == 1, 16'h0, 8'h0));
            et = ($urandom_range(0, 2) == 0) ? 16'h86DD : 16'h0800;
            case ($urandom_range(0, 4))
                0: ttl = 8'd0;
                1: ttl = 8'd1;
                2: ttl = 8'd2;
                3: ttl = 8'd255;
                default: ttl = 8'($urandom);
            endcase
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) drive(mk(k == 0, k == len - 1, et, ttl));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        bp_random = 0;
        stream_out_ready = 1'b1;
        drain();
        chk("final_drops", 600'(drop_count), 600'(exp_drops()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ttl_dec.md
Name: ttl_dec

Overview:
- IPv4 TTL-decrement stage in the l3fwd action pipe, directly upstream of the header checksum offload stage.
- On the first beat of each packet it checks the EtherType and TTL, decrements TTL, and forwards the packet.
- Packets whose TTL has expired (TTL ≤ 1) are dropped whole.
- It drives per-beat csum_enable/csum_start/csum_offset sideband, aligned to each output beat, to the checksum stage.

Parameters:
- DATA_WIDTH, 600, Avalon-ST data width in bits; must be ≥ 272 so the whole Eth+IPv4 header is in the SOP beat.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width.
- CHANNEL_WIDTH, 6, channel width.
- ERROR_WIDTH, 4, error width.
- AVST_ADDR_WIDTH, 9, width of csum_start/csum_offset bit indices.
- CNT_WIDTH, 32, drop counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stream_in_data  in  DATA_WIDTH  packet data; byte 0 at bits [DATA_WIDTH-1 -: 8]
- stream_in_empty  in  EMPTY_WIDTH  empty bytes on EOP beat
- stream_in_valid  in  1  valid
- stream_in_ready  out  1  ready
- stream_in_startofpacket  in  1  SOP
- stream_in_endofpacket  in  1  EOP
- stream_in_channel  in  CHANNEL_WIDTH  channel
- stream_in_error  in  ERROR_WIDTH  error
- stream_out_data / _empty / _valid / _startofpacket / _endofpacket / _channel / _error: same widths as the inputs; _valid is an output, every other field is an output
- stream_out_ready  in  1  ready
- csum_enable  out  1  output beat carries an IPv4 header needing checksum
- csum_start  out  AVST_ADDR_WIDTH  LSB bit index of the 160-bit IPv4 header: DATA_WIDTH-272
- csum_offset  out  AVST_ADDR_WIDTH  LSB bit index of the header checksum field: DATA_WIDTH-208
- drop_count  out  CNT_WIDTH  count of dropped packets

Behaviour:
- Output register stage: one-cycle latency; stream_in_ready = !stream_out_valid || stream_out_ready, except in DROP (see below).
- On out accept with no new input, stream_out_valid clears.
- Reset (async) values:
  - All stream_out_* outputs, csum_enable, csum_start, csum_offset and drop_count are 0.
  - State is IDLE.
- Field positions in the SOP beat:
  - EtherType: bits [DATA_WIDTH-97 -: 16].
  - TTL: bits [DATA_WIDTH-177 -: 8].
  - IPv4 is EtherType == 16'h0800.
- States: IDLE, FWD, DROP.
- IDLE, accepted SOP beat:
  - IPv4 and TTL ≥ 2: forward the beat with TTL replaced by TTL-1; csum_enable=1; csum_start/csum_offset set as above. If not EOP, go to FWD.
  - IPv4 and TTL ≤ 1: beat is consumed with no output. If EOP, drop_count increments and state stays IDLE; otherwise go to DROP.
  - Non-IPv4: forward unmodified, csum_enable=0. If not EOP, go to FWD.
- IDLE, accepted non-SOP beat: stray beat, consumed and discarded with no output; drop_count unchanged.
- FWD:
  - Beats are forwarded unmodified with csum_enable=0; csum_start/csum_offset are held.
  - Accepted EOP → IDLE.
  - A SOP beat arriving in FWD is handled as a new packet, as in IDLE (the previous packet is truncated).
- DROP:
  - stream_in_ready=1 unconditionally; no output is produced.
  - Accepted EOP → drop_count+1, → IDLE.
- drop_count saturates at all-ones; no wrap.
- Simultaneous output accept and input accept: the output register loads the new beat and valid stays 1.
- empty, channel and error pass through unchanged on forwarded beats.
- Reset mid-packet: state returns to IDLE and the output register is cleared. Any remaining beats of that packet arrive without SOP and are discarded as stray.
- The checksum itself is not modified; the downstream stage recomputes it from the csum sideband.

Optional Feature:
- TTL_DEC_DROP_CNT_EN
- Defined: drop_count is a live saturating counter, as described above.
- Undefined: no counter register is built and drop_count is tied to 0; drop behaviour is otherwise identical.

Test Plan:
- Single-beat IPv4 packet, EtherType 0800, TTL=64, stream_out_ready=1 → out one cycle later with TTL=63; all other bits unchanged; csum_enable=1, csum_start=328, csum_offset=392 (DATA_WIDTH=600).
- 3-beat IPv4 packet, TTL=1 → no output beats; stream_in_ready=1 throughout the packet; drop_count=1 after EOP.
- 2-beat ARP packet, EtherType 0806, TTL byte=0 → both beats forwarded unmodified; csum_enable=0 on both.
- stream_out_ready held 0 for 5 cycles mid-packet → out beat held stable; stream_in_ready=0; no beat lost or duplicated after ready returns to 1.
- Back-to-back packets with continuous valid, TTL=5 then TTL=0 then TTL=9 → outputs TTL=4 then TTL=8; drop_count=1; no bubble between forwarded packets.
- rst pulsed while in DROP, then tail beats without SOP, then a new SOP with TTL=10 → tail beats discarded; new packet forwarded with TTL=9; drop_count=0.
